// File: rtl/fetch_unit_if.sv
// Bus between the fetch sequencer, the program memory and the core.
// master: fetch_unit side; slave: memory/core/controller side.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              Start;
  logic [ADDR_W-1:0] MemAddr;
  logic [15:0]       MemData;
  logic [15:0]       DIN;
  logic              Run;
  logic              Done;
  logic [ADDR_W-1:0] PC;
  logic              Busy;
  logic              Halted;
  logic              Fault;

  modport master (
    input  Start, MemData, Done,
    output MemAddr, DIN, Run, PC, Busy, Halted, Fault
  );

  modport slave (
    output Start, MemData, Done,
    input  MemAddr, DIN, Run, PC, Busy, Halted, Fault
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: prefetches an instruction and its following word,
// feeds them to the core and advances the PC on Done, with halt and watchdog.
module fetch_unit #(
  parameter int unsigned       ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int unsigned       TIMEOUT   = 15,
  parameter logic [15:0]       HALT_WORD = 16'hFFFF
) (
  input logic          Clock,
  input logic          Resetn,
  fetch_unit_if.master bus
);

  localparam int unsigned WdogW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned CntW  = WdogW + 1;

  typedef enum logic [3:0] {
    StIdle,
    StRd0,
    StRd1,
    StCap1,
    StIssue,
    StImm,
    StWait,
    StHalt,
    StFault
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [15:0]       imm_q, imm_d;
  logic [WdogW-1:0]  wdog_q, wdog_d;
  logic              run_q, busy_q, halted_q, fault_q;

  logic [CntW-1:0]   wdog_inc;
  logic              timeout_hit;
  logic [ADDR_W-1:0] pc_next_instr;

  // Count in one extra bit so the compare against TIMEOUT cannot wrap.
  assign wdog_inc    = {1'b0, wdog_q} + CntW'(1);
  assign timeout_hit = (wdog_inc == CntW'(TIMEOUT));

  // mvi (low nibble 0001) consumes its immediate word as well.
  assign pc_next_instr = (ir_q[3:0] == 4'b0001) ? pc_q + ADDR_W'(2) : pc_q + ADDR_W'(1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    imm_d   = imm_q;
    wdog_d  = wdog_q;
    case (state_q)
      StIdle, StHalt, StFault: begin
        if (bus.Start) begin
          pc_d    = RESET_PC;
          state_d = StRd0;
        end
      end
      StRd0: state_d = StRd1;
      StRd1: begin
        ir_d    = bus.MemData;
        state_d = StCap1;
      end
      StCap1: begin
        imm_d = bus.MemData;
        if (ir_q == HALT_WORD) begin
          state_d = StHalt;
        end else begin
          wdog_d  = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        // Done in step 0 is a core protocol violation.
        if (bus.Done || timeout_hit) begin
          state_d = StFault;
        end else begin
          wdog_d  = wdog_inc[WdogW-1:0];
          state_d = StImm;
        end
      end
      StImm, StWait: begin
        if (bus.Done) begin
          pc_d    = pc_next_instr;
          state_d = StRd0;
        end else if (timeout_hit) begin
          state_d = StFault;
        end else begin
          wdog_d  = wdog_inc[WdogW-1:0];
          state_d = StWait;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      imm_q    <= '0;
      wdog_q   <= '0;
      run_q    <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      imm_q    <= imm_d;
      wdog_q   <= wdog_d;
      run_q    <= (state_d == StIssue) || (state_d == StImm) || (state_d == StWait);
      busy_q   <= !((state_d == StIdle) || (state_d == StHalt) || (state_d == StFault));
      halted_q <= (state_d == StHalt);
      fault_q  <= (state_d == StFault);
    end
  end

  always_comb begin
    bus.DIN = '0;
    case (state_q)
      StIssue:       bus.DIN = ir_q;
      StImm, StWait: bus.DIN = imm_q;
      default:       bus.DIN = '0;
    endcase
  end

  assign bus.MemAddr = (state_q == StRd1) ? pc_q + ADDR_W'(1) : pc_q;
  assign bus.PC      = pc_q;
  assign bus.Run     = run_q;
  assign bus.Busy    = busy_q;
  assign bus.Halted  = halted_q;
  assign bus.Fault   = fault_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch sequencer directly upstream of the processor core. It walks a program counter through a synchronous program memory and prefetches each instruction word and the word after it. It presents the instruction on `DIN` in the core's time step 0 and the following word in step 1, so that `mvi` receives its immediate. It holds `Run` until the core pulses `Done`, then advances the PC by 1, or by 2 for `mvi`. It also provides halt detection and a watchdog on a missing `Done`.

## Interface
- `ADDR_W`, 16: program-memory address width; the PC wraps modulo 2^ADDR_W.
- `RESET_PC`, 0: PC value after reset and on every `Start`.
- `TIMEOUT`, 15: maximum number of issued cycles without `Done` before a fault.
- `HALT_WORD`, 16'hFFFF: instruction word that halts fetching.
- `Clock` input 1: single clock; all state changes on the rising edge.
- `Resetn` input 1: reset, asynchronous, active-low.
- `Start` input 1: begin execution at `RESET_PC`; sampled only in IDLE, HALT and FAULT.
- `MemAddr` output ADDR_W: program-memory read address.
- `MemData` input 16: memory read data; the word for the address driven in cycle n is valid in cycle n+1.
- `DIN` output 16: word presented to the core.
- `Run` output 1: core enable, high while an instruction is in flight.
- `Done` input 1: single-cycle completion pulse from the core.
- `PC` output ADDR_W: address of the current instruction.
- `Busy` output 1: high in any state other than IDLE, HALT or FAULT.
- `Halted` output 1: high in HALT.
- `Fault` output 1: high in FAULT.

## Operation
- **Internal registers:** `pc`, `ir_buf[15:0]`, `imm_buf[15:0]`, `wdog`, and a state register.
- **States:** IDLE, RD0, RD1, CAP1, ISSUE, IMM, WAIT, HALT, FAULT.
- **IDLE:** `Start` loads `pc`=RESET_PC, then goes to RD0.
- **RD0:** `MemAddr`=`pc`, then goes to RD1.
- **RD1:** `MemAddr`=`pc`+1 (wrapping); captures `ir_buf`<=`MemData`; goes to CAP1.
- **CAP1:** captures `imm_buf`<=`MemData`.
  - If `ir_buf`==HALT_WORD, goes to HALT.
  - Otherwise clears `wdog` and goes to ISSUE.
- **ISSUE (core step 0):** `Run`=1, `DIN`=`ir_buf`; goes to IMM.
  - `Done` in this state is a protocol error and goes to FAULT.
- **IMM (core step 1):** `Run`=1, `DIN`=`imm_buf`.
  - `Done` here completes the instruction (the `mv` case).
  - Otherwise goes to WAIT.
- **WAIT:** `Run`=1, `DIN`=`imm_buf`; stays until `Done`.
- **Completion:** on `Done` in IMM or WAIT:
  - `pc` <= `pc` + 2 if `ir_buf[3:0]`==4'b0001 (`mvi`), else `pc` + 1, modulo 2^ADDR_W.
  - State goes to RD0.
- **Watchdog:** `wdog` increments in each of ISSUE, IMM and WAIT without `Done`. When it reaches TIMEOUT, the state goes to FAULT.
- **HALT / FAULT:** `Run`=0; `pc` is frozen at the offending instruction. `Start` restarts from RESET_PC via RD0.
- **Start while busy:** `Start` in any busy state is ignored.
- **Default outputs:** `MemAddr`=`pc` outside RD1. `DIN`=0 outside ISSUE, IMM and WAIT.
- **Reset (any state, including mid-instruction):**
  - State=IDLE, `pc`=RESET_PC, `ir_buf`=`imm_buf`=0, `wdog`=0.
  - Outputs: `Run`=0, `DIN`=0, `Busy`=0, `Halted`=0, `Fault`=0, `MemAddr`=RESET_PC.

## Timing
- **Start latency:** `Start` sampled at edge k. RD0 occupies cycle k..k+1, RD1 k+1..k+2, CAP1 k+2..k+3. ISSUE begins at edge k+3, so `Run` rises 3 cycles after the `Start` edge.
- **Refetch overhead:** between `Done` and the next ISSUE there are 3 cycles (RD0, RD1, CAP1) with `Run`=0.
- **`mv`:** 2 issued cycles (`Done` in IMM), 5 cycles per instruction in total.
- **`mvi`:** `Done` arrives in the WAIT cycle after IMM, 3 issued cycles.
- **ALU ops:** `Done` in core step 3, i.e. ISSUE, IMM, WAIT, WAIT; 4 issued cycles.
- **Outputs:** `Run` and `DIN` are registered or decoded from state only, never combinational from `Done`.
- **Wrap-around:** at `pc`=2^ADDR_W−1, the RD1 address wraps to 0. An `mvi` at that address completes with `pc`=1.

## Test plan
- **`mv`:** mem[0]=16'h0080 (`mv`), core pulses `Done` in IMM -> `DIN`=0x0080 then mem[1]; `pc` 0->1; next `Run` rises 3 cycles after `Done`.
- **`mvi`:** mem[0]=0x0001, mem[1]=0x1234, `Done` in WAIT -> `DIN`=0x0001 then 0x1234; `pc`=2; RD0 addresses mem[2].
- **Halt:** mem[2]=0xFFFF -> `Halted`=1, `Run` never asserts for it, `pc`=2. `Start` -> `pc`=0, `Busy`=1.
- **Watchdog:** `Done` withheld, TIMEOUT=15 -> `Fault`=1 after 15 issued cycles with `Run`=1, then `Run`=0.
- **Protocol error:** `Done` during ISSUE -> `Fault`=1 on the next cycle.
- **Reset and wrap:** `Resetn` low in WAIT -> all outputs at reset values immediately, without waiting for a clock edge. `mvi` at `pc`=0xFFFF -> immediate read from address 0, `pc`=1 after `Done`.
